pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL provide parameter D, default 12, meaning program-counter width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 4, meaning return-stack entries (DEPTH >= 1).
REQ-003 The block SHALL provide parameter OFFW, default 8, meaning signed relative-branch offset width (OFFW <= D).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Start, input, 1, the reset; synchronous, active-high.
REQ-006 The block SHALL have port Done, input, 1, a halt request.
REQ-007 The block SHALL have port Stall, input, 1, a hold for this cycle only.
REQ-008 The block SHALL have port Branch, input, 1, an absolute jump to target.
REQ-009 The block SHALL have port BranchRel, input, 1, a relative jump by offset.
REQ-010 The block SHALL have port Call, input, 1, which pushes the return address and jumps to target.
REQ-011 The block SHALL have port Ret, input, 1, which pops the return address and jumps to it.
REQ-012 The block SHALL have port target, input, D, the absolute destination.
REQ-013 The block SHALL have port offset, input, OFFW, a two's-complement relative displacement.
REQ-014 The block SHALL have port prog_ctr, output, D, the current instruction address.
REQ-015 The block SHALL have port depth, output, $clog2(DEPTH+1), the number of valid stack entries.
REQ-016 The block SHALL have port halted, output, 1, a sticky halt flag.
REQ-017 The block SHALL have port stk_ovf, output, 1, a sticky overflow flag (Call while full).
REQ-018 The block SHALL have port stk_unf, output, 1, a sticky underflow flag (Ret while empty).

Function
REQ-019 Next-state priority SHALL be: Start > halted-or-Done > Stall > Ret > Call > Branch > BranchRel > increment; only the highest-priority active action takes effect.
REQ-020 Increment SHALL set prog_ctr to prog_ctr+1 modulo 2^D (so 0xFFF becomes 0x000).
REQ-021 Branch SHALL load target into prog_ctr.
REQ-022 BranchRel SHALL load prog_ctr plus sign-extended offset, modulo 2^D.
REQ-023 Call while not full SHALL write (prog_ctr+1) mod 2^D at the stack top, increment depth, and load target.
REQ-024 Call while full (depth == DEPTH) SHALL load target, leave the stack and depth unchanged, and set stk_ovf.
REQ-025 Ret while not empty SHALL load the top entry into prog_ctr and decrement depth.
REQ-026 Ret while empty SHALL increment prog_ctr and set stk_unf.
REQ-027 Done SHALL set halted on the next edge; while halted is 1, prog_ctr, the stack, and the flags SHALL hold, and only Start SHALL clear halted.
REQ-028 Stall SHALL hold prog_ctr, the stack, and the flags for that cycle, with no side effects.
REQ-029 All outputs SHALL be registered, with one-cycle latency from control to prog_ctr.

Reset
REQ-030 Start SHALL force prog_ctr=0, depth=0, halted=0, stk_ovf=0, stk_unf=0 on the next edge, overriding every other input.
REQ-031 Start asserted mid-call-chain SHALL discard all stack contents; entry data need not be cleared, only depth.

Structure
REQ-032 Package pc_seq_pkg SHALL hold the next-PC select enum (NPC_HOLD, NPC_INC, NPC_ABS, NPC_REL, NPC_CALL, NPC_RET) and the priority decode function.
REQ-033 The return stack SHALL be a sub-module ret_stack (push, pop, din, dout, full, empty, depth), parameterised by D and DEPTH.

Verification
REQ-034 Verification SHALL cover: Start, then 5 idle cycles -> prog_ctr 0,1,2,3,4,5.
REQ-035 Verification SHALL cover: at prog_ctr=0x010, BranchRel with offset=0xF0 (-16) -> 0x000; at 0x000, offset=0xFF -> 0xFFF; next cycle -> 0x000.
REQ-036 Verification SHALL cover: Call target=0x100 at pc 0x020 -> pc 0x100, depth 1; Ret -> pc 0x021, depth 0.
REQ-037 Verification SHALL cover: 5 Calls with DEPTH=4 -> depth 4, stk_ovf=1, pc=target; 4 Rets unwind in LIFO order; a 5th Ret -> stk_unf=1, pc increments.
REQ-038 Verification SHALL cover: Done at pc 0x040 with Branch also asserted -> pc stays 0x040, halted=1; later Branch ignored; Start -> pc 0, halted 0.
REQ-039 Verification SHALL cover: Stall and Call in the same cycle -> pc and depth unchanged; next cycle Call alone takes effect.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - next-PC select encoding and priority decode for pc_seq
// Purpose: shared types for the program-counter sequencer.
//   npc_sel_e  : which source feeds the next program counter
//   npc_decode : collapses the control inputs (reset excluded) into one select
package pc_seq_pkg;

  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_INC,
    NPC_ABS,
    NPC_REL,
    NPC_CALL,
    NPC_RET
  } npc_sel_e;

  // Start is handled by the register reset path, so the decode starts at halt.
  function automatic npc_sel_e npc_decode(
    input logic halted,
    input logic done,
    input logic stall,
    input logic ret,
    input logic call,
    input logic branch,
    input logic branch_rel
  );
    if (halted || done) return NPC_HOLD;
    if (stall)          return NPC_HOLD;
    if (ret)            return NPC_RET;
    if (call)           return NPC_CALL;
    if (branch)         return NPC_ABS;
    if (branch_rel)     return NPC_REL;
    return NPC_INC;
  endfunction

endpackage

// File: rtl/pc_seq_ret_stack.sv
// rtl/pc_seq_ret_stack.sv - LIFO return-address stack for pc_seq
// Purpose: DEPTH-entry return stack of D-bit addresses.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, clears depth only
//   push  : write din on top (ignored when full)
//   pop   : drop top entry (ignored when empty)
//   din   : address to push
//   dout  : current top entry (meaningless when empty)
//   full  : depth == DEPTH
//   empty : depth == 0
//   depth : number of valid entries
module ret_stack #(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [D-1:0]               din,
  output logic [D-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [D-1:0]  mem_q [DEPTH];
  logic [CW-1:0] depth_q;
  logic [CW-1:0] top_idx;

  assign full    = (depth_q == CW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign depth   = depth_q;
  assign top_idx = depth_q - CW'(1);
  assign dout    = mem_q[AW'(top_idx)];

  // Entry storage is never cleared; depth alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem_q[AW'(depth_q)] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + CW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with call/return stack
// Purpose: registered program counter with branch, relative branch, call,
// return, stall and halt control.
// Ports:
//   clk       : clock
//   Start     : synchronous active-high reset
//   Done      : halt request (sticky until Start)
//   Stall     : hold everything this cycle
//   Branch    : jump to target
//   BranchRel : jump by signed offset
//   Call      : push pc+1, jump to target
//   Ret       : pop and jump to return address
//   target    : absolute destination
//   offset    : two's-complement displacement
//   prog_ctr  : current instruction address
//   depth     : valid return-stack entries
//   halted    : sticky halt flag
//   stk_ovf   : sticky Call-while-full flag
//   stk_unf   : sticky Ret-while-empty flag
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int D     = 12,
  parameter int DEPTH = 4,
  parameter int OFFW  = 8
) (
  input  logic                       clk,
  input  logic                       Start,
  input  logic                       Done,
  input  logic                       Stall,
  input  logic                       Branch,
  input  logic                       BranchRel,
  input  logic                       Call,
  input  logic                       Ret,
  input  logic [D-1:0]               target,
  input  logic [OFFW-1:0]            offset,
  output logic [D-1:0]               prog_ctr,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       halted,
  output logic                       stk_ovf,
  output logic                       stk_unf
);

  npc_sel_e     sel;
  logic [D-1:0] pc_q, pc_d, pc_inc, off_ext, stk_dout;
  logic         halted_q, halted_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         push, pop, full, empty;

  assign pc_inc  = pc_q + D'(1);
  assign off_ext = D'($signed(offset));

  always_comb begin
    sel      = npc_decode(halted_q, Done, Stall, Ret, Call, Branch, BranchRel);
    pc_d     = pc_q;
    halted_d = halted_q | Done;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push     = 1'b0;
    pop      = 1'b0;
    unique case (sel)
      NPC_HOLD: ;
      NPC_INC:  pc_d = pc_inc;
      NPC_ABS:  pc_d = target;
      NPC_REL:  pc_d = pc_q + off_ext;
      NPC_CALL: begin
        pc_d = target;
        if (full) ovf_d = 1'b1;
        else      push  = 1'b1;
      end
      NPC_RET: begin
        // Empty return falls through to a plain increment.
        if (empty) begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end else begin
          pc_d = stk_dout;
          pop  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Start) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  ret_stack #(
    .D    (D),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (Start),
    .push (push),
    .pop  (pop),
    .din  (pc_inc),
    .dout (stk_dout),
    .full (full),
    .empty(empty),
    .depth(depth)
  );

  assign prog_ctr = pc_q;
  assign halted   = halted_q;
  assign stk_ovf  = ovf_q;
  assign stk_unf  = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq
module tb_pc_seq;

  localparam int D     = 12;
  localparam int DEPTH = 4;
  localparam int OFFW  = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int MASK  = (1 << D) - 1;

  logic            clk = 1'b0;
  logic            Start = 1'b0, Done = 1'b0, Stall = 1'b0;
  logic            Branch = 1'b0, BranchRel = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [D-1:0]    target = '0;
  logic [OFFW-1:0] offset = '0;
  logic [D-1:0]    prog_ctr;
  logic [CW-1:0]   depth;
  logic            halted, stk_ovf, stk_unf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_seq #(.D(D), .DEPTH(DEPTH), .OFFW(OFFW)) dut (
    .clk(clk), .Start(Start), .Done(Done), .Stall(Stall),
    .Branch(Branch), .BranchRel(BranchRel), .Call(Call), .Ret(Ret),
    .target(target), .offset(offset),
    .prog_ctr(prog_ctr), .depth(depth), .halted(halted),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  // Reference model: pc as an integer, return stack as a queue.
  int m_pc;
  int m_stk[$];
  bit m_halt, m_ovf, m_unf, m_valid;

  always @(posedge clk) begin
    int o;
    o = int'(offset);
    if (o >= (1 << (OFFW - 1))) o -= (1 << OFFW);
    if (Start) begin
      m_pc = 0; m_stk.delete(); m_halt = 0; m_ovf = 0; m_unf = 0; m_valid = 1;
    end else if (m_halt || Done) begin
      m_halt = 1;
    end else if (Stall) begin
      // hold
    end else if (Ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = (m_pc + 1) & MASK; m_unf = 1; end
    end else if (Call) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) & MASK);
      else m_ovf = 1;
      m_pc = int'(target);
    end else if (Branch) begin
      m_pc = int'(target);
    end else if (BranchRel) begin
      m_pc = (m_pc + o) & MASK;
    end else begin
      m_pc = (m_pc + 1) & MASK;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_pc",     int'(prog_ctr), m_pc);
      chk("model_depth",  int'(depth),    m_stk.size());
      chk("model_halted", int'(halted),   int'(m_halt));
      chk("model_ovf",    int'(stk_ovf),  int'(m_ovf));
      chk("model_unf",    int'(stk_unf),  int'(m_unf));
    end
  end

  task automatic cyc(input bit st, input bit dn, input bit sl, input bit rt,
                     input bit cl, input bit br, input bit brl,
                     input int tgt, input int off);
    Start = st; Done = dn; Stall = sl; Ret = rt; Call = cl;
    Branch = br; BranchRel = brl;
    target = D'(tgt); offset = OFFW'(off);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input int tgt);
    cyc(0, 0, 0, 0, 0, 1, 0, tgt, 0);
  endtask

  task automatic call(input int tgt);
    cyc(0, 0, 0, 0, 1, 0, 0, tgt, 0);
  endtask

  task automatic ret();
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic start();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and free-running increment
    start();
    chk("rst_pc", int'(prog_ctr), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_flags", int'({halted, stk_ovf, stk_unf}), 0);
    for (int i = 1; i <= 5; i++) begin
      idle();
      chk("inc_pc", int'(prog_ctr), i);
    end

    // Relative branches with wrap
    jump('h010);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 'hF0);
    chk("rel_neg16", int'(prog_ctr), 'h000);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 'hFF);
    chk("rel_wrap_down", int'(prog_ctr), 'hFFF);
    idle();
    chk("inc_wrap_up", int'(prog_ctr), 'h000);

    // Single call/return
    jump('h020);
    call('h100);
    chk("call_pc", int'(prog_ctr), 'h100);
    chk("call_depth", int'(depth), 1);
    ret();
    chk("ret_pc", int'(prog_ctr), 'h021);
    chk("ret_depth", int'(depth), 0);

    // Overflow then LIFO unwind then underflow
    start();
    for (int i = 0; i < 5; i++) call('h200 + i);
    chk("ovf_depth", int'(depth), 4);
    chk("ovf_flag", int'(stk_ovf), 1);
    chk("ovf_pc", int'(prog_ctr), 'h204);
    ret(); chk("lifo_0", int'(prog_ctr), 'h203);
    ret(); chk("lifo_1", int'(prog_ctr), 'h202);
    ret(); chk("lifo_2", int'(prog_ctr), 'h201);
    ret(); chk("lifo_3", int'(prog_ctr), 'h001);
    chk("unwind_depth", int'(depth), 0);
    ret();
    chk("unf_flag", int'(stk_unf), 1);
    chk("unf_pc", int'(prog_ctr), 'h002);

    // Halt beats Branch, holds until Start
    jump('h040);
    cyc(0, 1, 0, 0, 0, 1, 0, 'h300, 0);
    chk("halt_pc", int'(prog_ctr), 'h040);
    chk("halt_flag", int'(halted), 1);
    jump('h300);
    chk("halt_hold_pc", int'(prog_ctr), 'h040);
    start();
    chk("halt_clr_pc", int'(prog_ctr), 0);
    chk("halt_clr_flag", int'(halted), 0);

    // Stall beats Call
    jump('h050);
    cyc(0, 0, 1, 0, 1, 0, 0, 'h123, 0);
    chk("stall_pc", int'(prog_ctr), 'h050);
    chk("stall_depth", int'(depth), 0);
    call('h123);
    chk("post_stall_pc", int'(prog_ctr), 'h123);
    chk("post_stall_depth", int'(depth), 1);

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) == 0,
          int'($urandom_range(0, MASK)),
          int'($urandom_range(0, 255)));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
